// File: rtl/wb_pipe_reg_if.sv
// wb_pipe_reg_if: control, capture, write-back and forwarding signals of the MEM/WB pipeline register
interface wb_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic              in_regwrite;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] src_rs;
  logic [ADDR_W-1:0] src_rt;
  logic              out_valid;
  logic              out_regwrite;
  logic [ADDR_W-1:0] out_rd;
  logic [DATA_W-1:0] out_data;
  logic              fwd_rs_hit;
  logic [DATA_W-1:0] fwd_rs_data;
  logic              fwd_rt_hit;
  logic [DATA_W-1:0] fwd_rt_data;
  modport master (
    output stall, flush, in_valid, in_regwrite, in_rd, in_data, src_rs, src_rt,
    input  out_valid, out_regwrite, out_rd, out_data, fwd_rs_hit, fwd_rs_data, fwd_rt_hit, fwd_rt_data
  );
  modport slave (
    input  stall, flush, in_valid, in_regwrite, in_rd, in_data, src_rs, src_rt,
    output out_valid, out_regwrite, out_rd, out_data, fwd_rs_hit, fwd_rs_data, fwd_rt_hit, fwd_rt_data
  );
endinterface

// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: DEPTH-stage MEM/WB register with stall, flush, sync reset and youngest-first forwarding
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 1
) (
  input logic          CLK,
  input logic          RST_N,
  wb_pipe_reg_if.slave bus
);
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;
  entry_t            st [DEPTH];
  entry_t            nxt;
  logic              rs_hit, rt_hit;
  logic [DATA_W-1:0] rs_data, rt_data;
  function automatic logic match(entry_t e, logic [ADDR_W-1:0] s);
    return e.valid & e.regwrite & (e.rd == s) & (s != '0);
  endfunction
  // a flush always turns stage 0 into a bubble, even while the rest of the pipe is stalled
  always_comb begin
    nxt = '0;
    if (!bus.flush) nxt = '{valid: bus.in_valid, regwrite: bus.in_valid & bus.in_regwrite & (bus.in_rd != '0),
                           rd: bus.in_rd, data: bus.in_data};
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int k = 0; k < DEPTH; k++) st[k] <= '0;
    end else begin
      if (!bus.stall || bus.flush) st[0] <= nxt;
      if (!bus.stall) for (int k = 1; k < DEPTH; k++) st[k] <= st[k-1];
    end
  end
  // walk oldest to youngest so the youngest matching stage wins
  always_comb begin
    rs_hit  = 1'b0;
    rs_data = '0;
    rt_hit  = 1'b0;
    rt_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match(st[k], bus.src_rs)) begin
        rs_hit  = 1'b1;
        rs_data = st[k].data;
      end
      if (match(st[k], bus.src_rt)) begin
        rt_hit  = 1'b1;
        rt_data = st[k].data;
      end
    end
  end
  assign bus.out_valid    = st[DEPTH-1].valid;
  assign bus.out_regwrite = st[DEPTH-1].regwrite;
  assign bus.out_rd       = st[DEPTH-1].rd;
  assign bus.out_data     = st[DEPTH-1].data;
  assign bus.fwd_rs_hit   = rs_hit;
  assign bus.fwd_rs_data  = rs_data;
  assign bus.fwd_rt_hit   = rt_hit;
  assign bus.fwd_rt_data  = rt_data;
endmodule

// File: tb/tb_wb_pipe_reg.sv
// tb_wb_pipe_reg: directed checks of DEPTH=1/2/3 instances sharing one stimulus stream
module tb_wb_pipe_reg;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_regwrite = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_data = '0;
  logic [4:0]  src_rs = '0;
  logic [4:0]  src_rt = '0;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 CLK = ~CLK;
  for (genvar g = 0; g < 3; g++) begin : d
    wb_pipe_reg_if b ();
    assign b.stall       = stall;
    assign b.flush       = flush;
    assign b.in_valid    = in_valid;
    assign b.in_regwrite = in_regwrite;
    assign b.in_rd       = in_rd;
    assign b.in_data     = in_data;
    assign b.src_rs      = src_rs;
    assign b.src_rt      = src_rt;
    wb_pipe_reg #(.DATA_W(32), .ADDR_W(5), .DEPTH(g + 1)) u (.CLK(CLK), .RST_N(RST_N), .bus(b));
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] dat);
    in_valid    = v;
    in_regwrite = rw;
    in_rd       = rd;
    in_data     = dat;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst d1 valid", 32'(d[0].b.out_valid), 32'd0);
    chk("rst d2 rd", 32'(d[1].b.out_rd), 32'd0);
    chk("rst d3 data", d[2].b.out_data, 32'd0);
    chk("rst d3 rs_hit", 32'(d[2].b.fwd_rs_hit), 32'd0);
    RST_N = 1'b1;
    // latency
    drive(1, 1, 5'd5, 32'h1234_5678);
    tick();
    drive(0, 0, 5'd0, 32'h0);
    chk("lat d1 rd@1", 32'(d[0].b.out_rd), 32'd5);
    chk("lat d1 rw@1", 32'(d[0].b.out_regwrite), 32'd1);
    chk("lat d3 valid@1", 32'(d[2].b.out_valid), 32'd0);
    tick();
    chk("lat d2 rd@2", 32'(d[1].b.out_rd), 32'd5);
    chk("lat d3 valid@2", 32'(d[2].b.out_valid), 32'd0);
    chk("lat d1 valid@2", 32'(d[0].b.out_valid), 32'd0);
    tick();
    chk("lat d3 rd@3", 32'(d[2].b.out_rd), 32'd5);
    chk("lat d3 data@3", d[2].b.out_data, 32'h1234_5678);
    chk("lat d3 rw@3", 32'(d[2].b.out_regwrite), 32'd1);
    chk("lat d3 valid@3", 32'(d[2].b.out_valid), 32'd1);
    // r0 suppression
    drive(1, 1, 5'd0, 32'hFFFF_FFFF);
    src_rs = 5'd0;
    tick();
    chk("r0 d1 valid", 32'(d[0].b.out_valid), 32'd1);
    chk("r0 d1 rw", 32'(d[0].b.out_regwrite), 32'd0);
    chk("r0 d3 rs_hit", 32'(d[2].b.fwd_rs_hit), 32'd0);
    drive(0, 0, 5'd0, 32'h0);
    tick();
    tick();
    chk("r0 d3 data", d[2].b.out_data, 32'hFFFF_FFFF);
    chk("r0 d3 rw", 32'(d[2].b.out_regwrite), 32'd0);
    chk("r0 d3 rs_hit late", 32'(d[2].b.fwd_rs_hit), 32'd0);
    // forward priority: stage2 (4,11) stage1 (4,22) stage0 (9,33)
    drive(1, 1, 5'd4, 32'h11);
    tick();
    drive(1, 1, 5'd4, 32'h22);
    tick();
    drive(1, 1, 5'd9, 32'h33);
    tick();
    drive(0, 0, 5'd0, 32'h0);
    src_rs = 5'd4;
    src_rt = 5'd9;
    #1;
    chk("pri d3 rs_hit", 32'(d[2].b.fwd_rs_hit), 32'd1);
    chk("pri d3 rs_data", d[2].b.fwd_rs_data, 32'h22);
    chk("pri d3 rt_hit", 32'(d[2].b.fwd_rt_hit), 32'd1);
    chk("pri d3 rt_data", d[2].b.fwd_rt_data, 32'h33);
    chk("pri d1 rs_hit", 32'(d[0].b.fwd_rs_hit), 32'd0);
    // same layout but stage1 invalid
    drive(1, 1, 5'd4, 32'h11);
    tick();
    drive(0, 1, 5'd4, 32'h22);
    tick();
    drive(1, 1, 5'd9, 32'h33);
    tick();
    drive(0, 0, 5'd0, 32'h0);
    chk("inv d3 rs_data", d[2].b.fwd_rs_data, 32'h11);
    chk("inv d3 rs_hit", 32'(d[2].b.fwd_rs_hit), 32'd1);
    chk("inv d2 rs_hit", 32'(d[1].b.fwd_rs_hit), 32'd0);
    // no-write entry
    drive(1, 0, 5'd6, 32'h66);
    tick();
    src_rt = 5'd6;
    #1;
    chk("nowr d1 rt_hit", 32'(d[0].b.fwd_rt_hit), 32'd0);
    chk("nowr d1 rt_data", d[0].b.fwd_rt_data, 32'd0);
    chk("nowr d1 valid", 32'(d[0].b.out_valid), 32'd1);
    // stall / flush on DEPTH=2: stage1 (2,20), stage0 (7,70)
    drive(1, 1, 5'd2, 32'h20);
    tick();
    drive(1, 1, 5'd7, 32'h70);
    tick();
    drive(1, 1, 5'd8, 32'h80);
    src_rs = 5'd7;
    stall  = 1'b1;
    tick();
    tick();
    chk("stl d2 rd", 32'(d[1].b.out_rd), 32'd2);
    chk("stl d2 data", d[1].b.out_data, 32'h20);
    chk("stl d2 rs_hit", 32'(d[1].b.fwd_rs_hit), 32'd1);
    chk("stl d2 rs_data", d[1].b.fwd_rs_data, 32'h70);
    flush = 1'b1;
    tick();
    chk("sf d2 rd", 32'(d[1].b.out_rd), 32'd2);
    chk("sf d2 valid", 32'(d[1].b.out_valid), 32'd1);
    chk("sf d2 rs_hit", 32'(d[1].b.fwd_rs_hit), 32'd0);
    stall = 1'b0;
    tick();
    chk("fl d2 valid", 32'(d[1].b.out_valid), 32'd0);
    chk("fl d2 rd", 32'(d[1].b.out_rd), 32'd0);
    chk("fl d2 data", d[1].b.out_data, 32'd0);
    flush = 1'b0;
    // reset mid-stream, with stall held high to show reset wins
    drive(1, 1, 5'd3, 32'hAAAA_0001);
    src_rs = 5'd3;
    tick();
    tick();
    chk("rm d2 rd pre", 32'(d[1].b.out_rd), 32'd3);
    chk("rm d2 rs_hit pre", 32'(d[1].b.fwd_rs_hit), 32'd1);
    RST_N = 1'b0;
    stall = 1'b1;
    tick();
    chk("rm d2 valid", 32'(d[1].b.out_valid), 32'd0);
    chk("rm d2 rd", 32'(d[1].b.out_rd), 32'd0);
    chk("rm d2 data", d[1].b.out_data, 32'd0);
    chk("rm d2 rs_hit", 32'(d[1].b.fwd_rs_hit), 32'd0);
    RST_N = 1'b1;
    stall = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
